// File: rtl/slave3_serial_port_if.sv
// Serial link between the address decoder's s3 slot and the slave3 endpoint.
//   rx    : decoder -> slave, bit-serial request, idles high
//   tx    : slave -> decoder, bit-serial response, idles high
//   busy  : decoder -> slave, asks the slave to hold a read in split
//   split : slave -> decoder, high while a read is held in split
//   done  : slave -> decoder, one-cycle pulse when a transaction completes
// Modports: slave (endpoint side), master (decoder / testbench side).
interface slave3_serial_port_if;
  logic rx;
  logic tx;
  logic busy;
  logic split;
  logic done;

  modport slave  (input rx, input busy, output tx, output split, output done);
  modport master (output rx, output busy, input tx, input split, input done);
endinterface

// File: rtl/slave3_serial_port.sv
// slave3_serial_port: serial slave endpoint behind the decoder's s3 port.
// Deframes LSB-first requests arriving on rx:
//   start(0), rw (1=write, 0=read), ADDR_W address bits, DATA_W data bits (writes only).
// Writes update an internal 2**ADDR_W x DATA_W register file. Reads answer on tx with a
// start bit (0), DATA_W data bits LSB first and a stop bit (1) that coincides with done.
// Ports:
//   clk  : bus clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : slave3_serial_port_if.slave (rx, busy in; tx, split, done out)
// Optional feature macro SPLIT_EN: when defined, a read whose last address bit sees
// busy=1 parks in SPLIT (split=1, tx=1) until busy is sampled low. When undefined the
// SPLIT state is not built, busy is ignored and split is tied low.
module slave3_serial_port #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  slave3_serial_port_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MAX_N = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = ($clog2(MAX_N) > 0) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    IDLE,
    RX_RW,
    RX_ADDR,
    RX_DATA,
    WRITE,
    TX_START,
    TX_DATA,
    TX_STOP
`ifdef SPLIT_EN
    , SPLIT
`endif
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt;
  logic                    rw;
  logic [ADDR_W-1:0]       addr_sr;
  logic [DATA_W-1:0]       wdata_sr;
  logic [DATA_W-1:0]       shift_sr;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic                    tx_o, split_o, done_o;

  // Bit counter never wraps; it parks on the final index of the current field.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic [CNT_W-1:0] lim);
    return (c >= lim) ? c : c + CNT_W'(1);
  endfunction

`ifndef SPLIT_EN
  logic unused_busy;
  assign unused_busy = bus.busy;
`endif

  // Next-state and Moore outputs
  always_comb begin
    state_n = state;
    tx_o    = 1'b1;
    split_o = 1'b0;
    done_o  = 1'b0;
    case (state)
      IDLE:     if (!bus.rx) state_n = RX_RW;
      RX_RW:    state_n = RX_ADDR;
      RX_ADDR: begin
        if (cnt == A_LAST) begin
          if (rw) begin
            state_n = RX_DATA;
          end else begin
`ifdef SPLIT_EN
            state_n = bus.busy ? SPLIT : TX_START;
`else
            state_n = TX_START;
`endif
          end
        end
      end
      RX_DATA:  if (cnt == D_LAST) state_n = WRITE;
      WRITE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
`ifdef SPLIT_EN
      SPLIT: begin
        split_o = 1'b1;
        if (!bus.busy) state_n = TX_START;
      end
`endif
      TX_START: begin
        tx_o    = 1'b0;
        state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_o = shift_sr[0];
        if (cnt == D_LAST) state_n = TX_STOP;
      end
      TX_STOP: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  // Control state, counter and register file
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      rw    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else                  cnt <= sat_inc(cnt, (state == RX_ADDR) ? A_LAST : D_LAST);
      if (state == RX_RW) rw <= bus.rx;
      if (state == WRITE) mem[addr_sr] <= wdata_sr;
    end
  end

  // Shift registers: fields arrive and leave LSB first
  always_ff @(posedge clk) begin
    if (state == RX_ADDR)  addr_sr  <= {bus.rx, addr_sr[ADDR_W-1:1]};
    if (state == RX_DATA)  wdata_sr <= {bus.rx, wdata_sr[DATA_W-1:1]};
    if (state == TX_START) shift_sr <= mem[addr_sr];
    else if (state == TX_DATA) shift_sr <= {1'b0, shift_sr[DATA_W-1:1]};
  end

  assign bus.tx    = tx_o;
  assign bus.split = split_o;
  assign bus.done  = done_o;

endmodule

// File: tb/tb_slave3_serial_port.sv
`timescale 1ns/1ps
module tb_slave3_serial_port;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rstn;
  int   nvec = 0;
  int   nerr = 0;
  logic [DW-1:0] ref_mem [2**AW];

  slave3_serial_port_if bus();

  slave3_serial_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
  endtask

  task automatic idle(input int n);
    bus.rx   = 1'b1;
    bus.busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      nvec++;
      if (bus.tx !== 1'b1 || bus.split !== 1'b0 || bus.done !== 1'b0) begin
        nerr++;
        $display("FAIL idle tx/split/done got %b%b%b need 100", bus.tx, bus.split, bus.done);
      end
      tick();
    end
  endtask

  // Full write frame; done is expected in the cycle after the last data bit.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
    for (int k = 0; k <= AW + DW + 2; k++) begin
      if (k == 0)                bus.rx = 1'b0;
      else if (k == 1)           bus.rx = 1'b1;
      else if (k < AW + 2)       bus.rx = a[k-2];
      else if (k < AW + DW + 2)  bus.rx = d[k-AW-2];
      else                       bus.rx = 1'b1;
      bus.busy = 1'($urandom_range(0, 1));
      nvec++;
      if (bus.tx !== 1'b1) begin
        nerr++;
        $display("FAIL %s cyc %0d tx got %b need 1", name, k, bus.tx);
      end
      nvec++;
      if (bus.split !== 1'b0) begin
        nerr++;
        $display("FAIL %s cyc %0d split got %b need 0", name, k, bus.split);
      end
      nvec++;
      if (bus.done !== (k == AW + DW + 2)) begin
        nerr++;
        $display("FAIL %s cyc %0d done got %b need %b", name, k, bus.done, (k == AW + DW + 2));
      end
      tick();
    end
    bus.busy = 1'b0;
    ref_mem[a] = d;
  endtask

  // Read frame. drop=0: busy low at the last address bit. drop>0: busy high from the last
  // address bit until cycle drop, where it falls; only a split build waits for it.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input int drop, input string name);
    int hold, ts, last;
    logic etx, esp, edn;
`ifdef SPLIT_EN
    hold = (drop > 0) ? drop - (AW + 1) : 0;
`else
    hold = 0;
`endif
    ts   = AW + 2 + hold;
    last = ts + DW + 1;
    for (int k = 0; k <= last; k++) begin
      if (k == 0 || k == 1)  bus.rx = 1'b0;
      else if (k < AW + 2)   bus.rx = a[k-2];
      else                   bus.rx = 1'b1;
      if (k < AW + 1)                    bus.busy = 1'($urandom_range(0, 1));
      else if (k == AW + 1)              bus.busy = (drop > 0);
      else if (drop > 0 && k < drop)     bus.busy = 1'b1;
      else if (drop > 0 && k == drop)    bus.busy = 1'b0;
      else                               bus.busy = 1'($urandom_range(0, 1));
      etx = (k == ts) ? 1'b0 : ((k > ts && k <= ts + DW) ? exp[k-ts-1] : 1'b1);
      esp = (k >= AW + 2 && k < ts);
      edn = (k == last);
      nvec++;
      if (bus.tx !== etx) begin
        nerr++;
        $display("FAIL %s cyc %0d tx got %b need %b", name, k, bus.tx, etx);
      end
      nvec++;
      if (bus.split !== esp) begin
        nerr++;
        $display("FAIL %s cyc %0d split got %b need %b", name, k, bus.split, esp);
      end
      nvec++;
      if (bus.done !== edn) begin
        nerr++;
        $display("FAIL %s cyc %0d done got %b need %b", name, k, bus.done, edn);
      end
      tick();
    end
    bus.busy = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] a3 = 4'd3;
    nvec++;
    if (bus.tx !== 1'b1 || bus.split !== 1'b0 || bus.done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state tx/split/done got %b%b%b need 100", bus.tx, bus.split, bus.done);
    end
    #6 rstn = 1'b1;
    tick();
    idle(2);
    do_write(3, 8'h77, "reset_prewrite");
    idle(1);
    // Start a read and pulse reset while the response start bit is on tx.
    for (int k = 0; k <= AW + 2; k++) begin
      if (k == 0 || k == 1) bus.rx = 1'b0;
      else if (k < AW + 2)  bus.rx = a3[k-2];
      else                  bus.rx = 1'b1;
      if (k == AW + 2) begin
        nvec++;
        if (bus.tx !== 1'b0) begin
          nerr++;
          $display("FAIL reset_prepulse tx got %b need 0", bus.tx);
        end
        #3;
        rstn = 1'b0;
        #0.001;
        nvec++;
        if (bus.tx !== 1'b1 || bus.split !== 1'b0 || bus.done !== 1'b0) begin
          nerr++;
          $display("FAIL reset_pulse tx/split/done got %b%b%b need 100", bus.tx, bus.split, bus.done);
        end
        rstn = 1'b1;
        model_reset();
      end
      tick();
    end
    idle(2);
    do_read(3, ref_mem[3], 0, "reset_read3");
    idle(1);
  endtask

  task automatic test_write_read();
    do_write(5, 8'hA5, "write5");
    idle(1);
    do_read(5, ref_mem[5], 0, "read5");
    idle(1);
  endtask

  task automatic test_split();
    do_read(5, ref_mem[5], 40, "split_read5");
    idle(1);
  endtask

  task automatic test_reset_midframe();
    logic [AW-1:0] a15 = 4'd15;
    for (int k = 0; k <= AW + 1; k++) begin
      if (k == 0)      bus.rx = 1'b0;
      else if (k == 1) bus.rx = 1'b1;
      else             bus.rx = a15[k-2];
      if (k == AW + 1) begin
        #3;
        bus.rx = 1'b1;
        rstn = 1'b0;
        #0.001;
        rstn = 1'b1;
        model_reset();
      end
      tick();
    end
    idle(2);
    do_read(15, ref_mem[15], 0, "abort_read15");
    idle(1);
    do_write(15, 8'h3C, "write15");
    idle(1);
    do_read(15, ref_mem[15], 0, "read15");
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d = 8'($urandom);
    do_write(9, d, "b2b_write9");
    do_read(9, ref_mem[9], 0, "b2b_read9");
    do_read(9, ref_mem[9], 0, "b2b_read9_again");
    idle(1);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int drop;
    for (int n = 0; n < 30; n++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = DW'($urandom);
        do_write(a, d, "rand_write");
      end else begin
        drop = ($urandom_range(0, 2) == 0) ? AW + 2 + int'($urandom_range(0, 10)) : 0;
        do_read(a, ref_mem[a], drop, "rand_read");
      end
      idle(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    rstn     = 1'b0;
    bus.rx   = 1'b1;
    bus.busy = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_write_read();
    test_split();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
